// File: rtl/systolic_feed_sched_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic array read-side feed scheduler.
//   - FSM state encoding, shared by the top and anything that decodes state.
//   - row_active(): the skew window test. Row `row` reads at step `step` when
//     row <= step < row + len.
// -----------------------------------------------------------------------------
package systolic_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Computed in 32 bits so row + len cannot wrap for any legal CNT_W/N.
    function automatic logic row_active(input int unsigned row,
                                        input int unsigned step,
                                        input int unsigned len);
        return (step >= row) && (step < (row + len));
    endfunction

endpackage

// File: rtl/systolic_feed_sched_if.sv
// -----------------------------------------------------------------------------
// systolic_feed_sched_if
// Control/status bundle between a feed controller (master) and the
// scheduler (slave).
//   start, len              : schedule request (master -> slave)
//   fifo_empty, fifo_wen    : row FIFO status (master -> slave)
//   fifo_ren                : row FIFO read enables (slave -> master)
//   col_valid, array_en     : array-side qualifiers (slave -> master)
//   busy, done              : schedule status (slave -> master)
// -----------------------------------------------------------------------------
interface systolic_feed_sched_if #(
    parameter int N     = 3,
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic [N-1:0]     fifo_empty;
    logic [N-1:0]     fifo_wen;
    logic [N-1:0]     fifo_ren;
    logic [N-1:0]     col_valid;
    logic             array_en;
    logic             busy;
    logic             done;

    modport master (
        output start, len, fifo_empty, fifo_wen,
        input  fifo_ren, col_valid, array_en, busy, done
    );

    modport slave (
        input  start, len, fifo_empty, fifo_wen,
        output fifo_ren, col_valid, array_en, busy, done
    );

endinterface

// File: rtl/systolic_skew_window.sv
// -----------------------------------------------------------------------------
// systolic_skew_window
// Combinational skew window: bit i of active_o is high when row i is inside
// its read window at schedule step step_i for a schedule of len_i words.
//   step_i   : current schedule step (CNT_W+1 bits)
//   len_i    : latched words-per-row
//   active_o : per-row active vector
// -----------------------------------------------------------------------------
module systolic_skew_window
    import systolic_pkg::*;
#(
    parameter int N     = 3,
    parameter int CNT_W = 8
) (
    input  logic [CNT_W:0]   step_i,
    input  logic [CNT_W-1:0] len_i,
    output logic [N-1:0]     active_o
);

    for (genvar i = 0; i < N; i++) begin : g_row
        assign active_o[i] = row_active(32'(i), 32'(step_i), 32'(len_i));
    end

endmodule

// File: rtl/systolic_feed_sched.sv
// -----------------------------------------------------------------------------
// systolic_feed_sched
// Read-side scheduler for the N row FIFOs feeding a systolic array. A start
// launches a skewed read schedule (row i starts i steps after row 0, each row
// reads len words). The whole schedule stalls in lockstep while any active
// row cannot be read, then a DRAIN_CYC-cycle drain window flushes the array
// and done pulses for one cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of systolic_feed_sched_if (start/len, FIFO status,
//              fifo_ren, col_valid, array_en, busy, done)
// -----------------------------------------------------------------------------
module systolic_feed_sched
    import systolic_pkg::*;
#(
    parameter int N         = 3,
    parameter int CNT_W     = 8,
    parameter int DRAIN_CYC = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    systolic_feed_sched_if.slave bus
);

    localparam int STEP_W  = CNT_W + 1;
    localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [N-1:0]       col_valid_q;
    logic               array_en_q;
    logic               done_q;

    logic [N-1:0]       active_s;
    logic [N-1:0]       ready_s;
    logic [N-1:0]       ren_s;
    logic               step_ok_s;
    logic               run_s;
    logic               drain_s;
    logic [STEP_W-1:0]  last_step_s;

    systolic_skew_window #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_window (
        .step_i   (step_q),
        .len_i    (len_q),
        .active_o (active_s)
    );

    // Lockstep stall detection and read-enable generation.
    always_comb begin
        run_s   = (state_q == ST_RUN);
        drain_s = (state_q == ST_DRAIN);
        // A write landing in the same cycle makes the FIFO drop the read,
        // so such a row is treated as not ready.
        ready_s   = ~bus.fifo_empty & ~bus.fifo_wen;
        // Inactive rows never hold the schedule back.
        step_ok_s = &(ready_s | ~active_s);
        // Gated by rst so an abort issues no read in the reset cycle either.
        if (run_s && step_ok_s && !rst) begin
            ren_s = active_s;
        end else begin
            ren_s = {N{1'b0}};
        end
        // Last step index L+N-2; only used in RUN where L >= 1, so no underflow.
        last_step_s = {1'b0, len_q} + STEP_W'(N) - STEP_W'(2);
    end

    // Next-state logic for the FSM, step counter, drain counter and length.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        len_d   = len_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    len_d  = bus.len;
                    step_d = {STEP_W{1'b0}};
                    if (bus.len == {CNT_W{1'b0}}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (step_ok_s) begin
                    step_d = step_q + STEP_W'(1);
                    if (step_q == last_step_s) begin
                        state_d = ST_DRAIN;
                        drain_d = {DRAIN_W{1'b0}};
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_q      <= {STEP_W{1'b0}};
            len_q       <= {CNT_W{1'b0}};
            drain_q     <= {DRAIN_W{1'b0}};
            col_valid_q <= {N{1'b0}};
            array_en_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            len_q       <= len_d;
            drain_q     <= drain_d;
            // FIFO q_out is registered, so valid data trails the read by one.
            col_valid_q <= ren_s;
            array_en_q  <= (run_s & step_ok_s) | drain_s;
            // Registered so the pulse coincides with the DONE state cycle.
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign bus.fifo_ren  = ren_s;
    assign bus.col_valid = col_valid_q;
    assign bus.array_en  = array_en_q;
    assign bus.done      = done_q;
    assign bus.busy      = run_s | drain_s;

endmodule

// File: tb/tb_systolic_feed_sched.sv
// -----------------------------------------------------------------------------
// tb_systolic_feed_sched
// Directed, table-driven bench for systolic_feed_sched (N=3, CNT_W=8,
// DRAIN_CYC=5). Expected per-cycle outputs come from closed-form schedule
// timing: cycle c of a run maps to an effective cycle e (c minus stalls so
// far); row i reads when 1+i <= e <= L+i, the schedule is busy for
// 1 <= e <= L+N-1+D and done pulses at e = L+N+D.
// -----------------------------------------------------------------------------
module tb_systolic_feed_sched;

    localparam int N     = 3;
    localparam int CNT_W = 8;
    localparam int D     = 5;
    localparam int NCYC  = 16;

    typedef struct {
        logic             rst;
        logic             start;
        logic [CNT_W-1:0] len;
        logic [N-1:0]     empty;
        logic [N-1:0]     wen;
        logic [N-1:0]     ren;
        logic [N-1:0]     col;
        logic             aen;
        logic             busy;
        logic             done;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs[$];

    systolic_feed_sched_if #(.N(N), .CNT_W(CNT_W)) bus_if ();

    systolic_feed_sched #(
        .N         (N),
        .CNT_W     (CNT_W),
        .DRAIN_CYC (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected outputs in cycle c of a run of length L with one stall at s (-1: none).
    function automatic vec_t exp_vec(input int c, input int L, input int s);
        vec_t v;
        int   e;
        int   ep;
        v.rst   = 1'b0;
        v.start = 1'b0;
        v.len   = CNT_W'(L);
        v.empty = '0;
        v.wen   = '0;
        v.ren   = '0;
        v.col   = '0;
        v.aen   = 1'b0;
        v.busy  = 1'b0;
        v.done  = 1'b0;
        if (L == 0) begin
            v.done = (c == 1);
            return v;
        end
        e  = (s >= 0 && c > s) ? c - 1 : c;
        ep = (s >= 0 && c - 1 > s) ? c - 2 : c - 1;
        for (int i = 0; i < N; i++) begin
            if (c != s && e >= 1 + i && e <= L + i) v.ren[i] = 1'b1;
            if (c >= 1 && c - 1 != s && ep >= 1 + i && ep <= L + i) v.col[i] = 1'b1;
        end
        v.busy = (e >= 1 && e <= L + N - 1 + D);
        v.aen  = (c >= 1 && c - 1 != s && ep >= 1 && ep <= L + N - 1 + D);
        v.done = (e == L + N + D);
        return v;
    endfunction

    task automatic build(input int L, input int s, input int emp_c, input logic [N-1:0] emp_m,
                         input int wen_c, input logic [N-1:0] wen_m);
        vec_t v;
        for (int c = 0; c < NCYC; c++) begin
            v       = exp_vec(c, L, s);
            v.start = (c == 0);
            v.empty = (c == emp_c) ? emp_m : '0;
            v.wen   = (c == wen_c) ? wen_m : '0;
            vecs.push_back(v);
        end
    endtask

    task automatic apply_vecs(input string tag);
        for (int k = 0; k < vecs.size(); k++) begin
            rst                = vecs[k].rst;
            bus_if.start       = vecs[k].start;
            bus_if.len         = vecs[k].len;
            bus_if.fifo_empty  = vecs[k].empty;
            bus_if.fifo_wen    = vecs[k].wen;
            @(negedge clk);
            check($sformatf("%s[%0d].ren", tag, k),  32'(bus_if.fifo_ren),  32'(vecs[k].ren));
            check($sformatf("%s[%0d].col", tag, k),  32'(bus_if.col_valid), 32'(vecs[k].col));
            check($sformatf("%s[%0d].aen", tag, k),  32'(bus_if.array_en),  32'(vecs[k].aen));
            check($sformatf("%s[%0d].busy", tag, k), 32'(bus_if.busy),      32'(vecs[k].busy));
            check($sformatf("%s[%0d].done", tag, k), 32'(bus_if.done),      32'(vecs[k].done));
            @(posedge clk);
            #1;
        end
        vecs.delete();
    endtask

    task automatic drive(input logic r, input logic st, input int L);
        rst               = r;
        bus_if.start      = st;
        bus_if.len        = CNT_W'(L);
        bus_if.fifo_empty = '0;
        bus_if.fifo_wen   = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        checks = 0;
        errors = 0;
        drive(1'b1, 1'b0, 0);

        // Reset state
        next_cycle();
        @(negedge clk);
        check("rst.ren",  32'(bus_if.fifo_ren),  32'd0);
        check("rst.col",  32'(bus_if.col_valid), 32'd0);
        check("rst.aen",  32'(bus_if.array_en),  32'd0);
        check("rst.busy", 32'(bus_if.busy),      32'd0);
        check("rst.done", 32'(bus_if.done),      32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 0);
        next_cycle();

        // Directed schedules: L, stall cycle, empty inject, wen inject
        build(4, -1, -1, 3'b000, -1, 3'b000);   // plain L=4
        build(4,  3,  3, 3'b010, -1, 3'b000);   // row 1 empty mid-run
        build(4, -1, -1, 3'b000,  1, 3'b100);   // wen on inactive row 2
        build(4,  2, -1, 3'b000,  2, 3'b001);   // wen on active row 0
        build(0, -1, -1, 3'b000, -1, 3'b000);   // zero length
        build(1, -1, -1, 3'b000, -1, 3'b000);   // single word per row
        build(4, -1,  1, 3'b100, -1, 3'b000);   // empty on inactive row 2
        apply_vecs("tbl");

        // Reset in cycle 3 of a len=4 run
        drive(1'b0, 1'b1, 4);
        next_cycle();
        drive(1'b0, 1'b0, 4);
        @(negedge clk);
        check("abort.c1.ren", 32'(bus_if.fifo_ren), 32'd1);
        next_cycle();
        @(negedge clk);
        check("abort.c2.ren", 32'(bus_if.fifo_ren), 32'd3);
        next_cycle();
        drive(1'b1, 1'b0, 4);
        @(negedge clk);
        check("abort.c3.ren", 32'(bus_if.fifo_ren), 32'd0);
        next_cycle();
        drive(1'b0, 1'b0, 4);
        for (int c = 4; c < 7; c++) begin
            @(negedge clk);
            check($sformatf("abort.c%0d.ren", c),  32'(bus_if.fifo_ren),  32'd0);
            check($sformatf("abort.c%0d.col", c),  32'(bus_if.col_valid), 32'd0);
            check($sformatf("abort.c%0d.aen", c),  32'(bus_if.array_en),  32'd0);
            check($sformatf("abort.c%0d.busy", c), 32'(bus_if.busy),      32'd0);
            check($sformatf("abort.c%0d.done", c), 32'(bus_if.done),      32'd0);
            next_cycle();
        end
        build(4, -1, -1, 3'b000, -1, 3'b000);
        apply_vecs("after_abort");

        // start held high: second run begins the cycle after IDLE is re-entered
        for (int c = 0; c <= 26; c++) begin
            v       = (c < 13) ? exp_vec(c, 4, -1) : exp_vec(c - 13, 4, -1);
            v.start = 1'b1;
            vecs.push_back(v);
        end
        apply_vecs("hold");

        drive(1'b1, 1'b0, 0);
        next_cycle();
        drive(1'b0, 1'b0, 0);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
